// File: rtl/bram_ctrl_pkg.sv
// Shared types and constants for the BRAM burst access controller.
// The state enum carries the FSM encoding; the mode constants decode mode_i.
package bram_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    WRITE = ST_WRITE,
    READ  = ST_READ,
    DONE  = ST_DONE
  } state_t;

  localparam logic MODE_WR = 1'b0;
  localparam logic MODE_RD = 1'b1;

  // Read-side credit limit: FIFO entries plus reads still inside the BRAM.
  localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/bram_access_ctrl_addr_gen.sv
// Address counter used for both the write and the read side of a burst.
// Clear takes priority over increment so the last access can also end the burst.
module addr_gen #(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [AWIDTH-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bram_access_ctrl.sv
// Burst sequencer for one single-port BRAM: streams words in (write mode) or out
// (read mode) at addresses 0..len-1, with a 2-entry return FIFO for backpressure.
module bram_access_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [AWIDTH-1:0] len_i,
  output logic              idle_o,
  output logic              done_o,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DWIDTH-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DWIDTH-1:0] m_data_o,
  output logic              bram_ce_o,
  output logic              bram_we_o,
  output logic [AWIDTH-1:0] bram_addr_o,
  output logic [DWIDTH-1:0] bram_d_o,
  input  logic [DWIDTH-1:0] bram_q_i
);

  state_t state_reg;
  state_t state_next;

  logic [AWIDTH-1:0] len_reg;
  logic [AWIDTH-1:0] wr_cnt;
  logic [AWIDTH-1:0] rd_cnt;

  logic [DWIDTH-1:0] fifo_mem [0:1];
  logic              fifo_wr_ptr;
  logic              fifo_rd_ptr;
  logic [1:0]        fifo_count;
  logic              inflight_reg;

  logic              wr_fire;
  logic              rd_issue;
  logic              fifo_push;
  logic              fifo_pop;
  logic              last_pop;
  logic              cnt_clr;
  logic [1:0]        occ_after_pop;
  logic [1:0]        credits_used;

  // ---------------------------------------------------------------------------
  // Handshakes and read-issue credit
  // ---------------------------------------------------------------------------
  assign wr_fire   = (state_reg == WRITE) && s_valid_i;
  assign fifo_push = inflight_reg;
  assign fifo_pop  = (fifo_count != 2'd0) && m_ready_i;

  // A word leaving the FIFO this cycle frees its slot for an issue in the same
  // cycle; without that credit the 2-cycle BRAM loop could not sustain 1 word/clk.
  assign occ_after_pop = fifo_count - {1'b0, fifo_pop};
  assign credits_used  = occ_after_pop + {1'b0, inflight_reg};
  assign rd_issue      = (state_reg == READ) && (rd_cnt < len_reg) &&
                         (credits_used < FIFO_DEPTH);

  assign last_pop = fifo_pop && (fifo_count == 2'd1) && !inflight_reg &&
                    (rd_cnt == len_reg);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && start_i) begin
        len_reg <= len_i;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            state_next = DONE;
          end else begin
            case (mode_i)
              MODE_WR: state_next = WRITE;
              MODE_RD: state_next = READ;
              default: state_next = IDLE;
            endcase
          end
        end
      end
      WRITE: begin
        if (wr_fire && (wr_cnt == len_reg - 1'b1)) begin
          state_next = DONE;
        end
      end
      READ: begin
        if (last_pop) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters restart for every burst; clearing on DONE entry also covers the
  // final access, which would otherwise leave the count at len.
  assign cnt_clr = (state_next == DONE) || (state_reg == IDLE);

  addr_gen #(.AWIDTH(AWIDTH)) u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (wr_fire),
    .cnt   (wr_cnt)
  );

  addr_gen #(.AWIDTH(AWIDTH)) u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (rd_issue),
    .cnt   (rd_cnt)
  );

  // ---------------------------------------------------------------------------
  // Read return path: one-cycle BRAM latency tracked by inflight_reg
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_reg <= 1'b0;
      fifo_wr_ptr  <= 1'b0;
      fifo_rd_ptr  <= 1'b0;
      fifo_count   <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      inflight_reg <= rd_issue;
      if (fifo_push) begin
        fifo_mem[fifo_wr_ptr] <= bram_q_i;
        fifo_wr_ptr           <= ~fifo_wr_ptr;
      end
      if (fifo_pop) begin
        fifo_rd_ptr <= ~fifo_rd_ptr;
      end
      fifo_count <= fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign idle_o    = (state_reg == IDLE);
  assign done_o    = (state_reg == DONE);
  assign s_ready_o = (state_reg == WRITE);

  assign m_valid_o = (fifo_count != 2'd0);
  assign m_data_o  = m_valid_o ? fifo_mem[fifo_rd_ptr] : '0;

  assign bram_ce_o   = wr_fire || rd_issue;
  assign bram_we_o   = wr_fire;
  assign bram_addr_o = wr_fire ? wr_cnt : (rd_issue ? rd_cnt : '0);
  assign bram_d_o    = wr_fire ? s_data_i : '0;

endmodule

// File: tb/tb_bram_access_ctrl.sv
// Directed bench for bram_access_ctrl with a behavioural BRAM and a scoreboard
// of expected writes and expected read-stream words.
module tb_bram_access_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [AW-1:0] len;
  logic          idle;
  logic          done;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          bram_ce;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_d;
  logic [DW-1:0] bram_q;

  bram_access_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start),
    .mode_i      (mode),
    .len_i       (len),
    .idle_o      (idle),
    .done_o      (done),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_data_i    (s_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .bram_ce_o   (bram_ce),
    .bram_we_o   (bram_we),
    .bram_addr_o (bram_addr),
    .bram_d_o    (bram_d),
    .bram_q_i    (bram_q)
  );

  always #5 clk = ~clk;

  // Behavioural single-port BRAM, registered read.
  logic [DW-1:0] bram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bram_ce) begin
      if (bram_we) bram_mem[bram_addr] <= bram_d;
      else         bram_q <= bram_mem[bram_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  logic [AW+DW-1:0] wr_q [$];
  logic [DW-1:0]    rd_q [$];
  logic [DW-1:0]    shadow [0:(1<<AW)-1];

  int            issued, popped, done_cnt, wr_count;
  logic [AW-1:0] next_rd_addr, last_wr_addr;
  logic          cyc_ce, cyc_wr, cyc_issue, cyc_pop, cyc_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven: samples this cycle,
  // scores it, then advances to the next falling edge.
  task automatic step();
    logic [AW+DW-1:0] e;
    #1;
    cyc_ce    = bram_ce;
    cyc_wr    = bram_ce && bram_we;
    cyc_issue = bram_ce && !bram_we;
    cyc_pop   = m_valid && m_ready;
    cyc_done  = done;
    if (cyc_wr) begin
      wr_count++;
      last_wr_addr = bram_addr;
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", 64'(bram_addr), 64'hFFFF);
      end else begin
        e = wr_q.pop_front();
        chk("wr_addr", 64'(bram_addr), 64'(e[AW+DW-1:DW]));
        chk("wr_data", 64'(bram_d), 64'(e[DW-1:0]));
      end
    end
    if (cyc_issue) begin
      chk("rd_issue_addr", 64'(bram_addr), 64'(next_rd_addr));
      next_rd_addr++;
      issued++;
    end
    if (cyc_pop) begin
      popped++;
      if (rd_q.size() == 0) chk("rd_extra_word", 64'(m_data), 64'hDEAD_BEEF_0000);
      else                  chk("rd_data", 64'(m_data), 64'(rd_q.pop_front()));
    end
    if (cyc_issue) chk("outstanding_le2", 64'((issued - popped) <= 2), 64'd1);
    if (cyc_done) done_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_burst(input logic md, input logic [AW-1:0] ln);
    issued = 0; popped = 0; done_cnt = 0; wr_count = 0; next_rd_addr = '0;
    start = 1'b1; mode = md; len = ln;
    step();
    start = 1'b0; mode = 1'b0; len = '0;
  endtask

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    wr_q.push_back({a, d});
    shadow[a] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_pop, last_pop, done_k;
    logic [5:0] gap_pat;
    int j;

    reset = 1'b1; start = 1'b0; mode = 1'b0; len = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    issued = 0; popped = 0; done_cnt = 0; wr_count = 0;
    next_rd_addr = '0; last_wr_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ce", 64'(bram_ce), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: write burst, 4 words back to back
    start_burst(1'b0, 8'd4);
    for (int i = 0; i < 4; i++) begin
      push_write(AW'(i), 32'hA0A0_0000 + DW'(i));
      chk("t1_s_ready", 64'(s_ready), 64'd1);
      step();
      chk("t1_wr_consec", 64'(cyc_wr), 64'd1);
    end
    s_valid = 1'b0;
    step();
    chk("t1_done", 64'(cyc_done), 64'd1);
    chk("t1_wr_q_empty", 64'(wr_q.size()), 64'd0);
    #1;
    chk("t1_idle_back", 64'(idle), 64'd1);
    chk("t1_done_once", 64'(done_cnt), 64'd1);

    // 2: read back, no backpressure
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) rd_q.push_back(shadow[i]);
    start_burst(1'b1, 8'd4);
    first_pop = -1; last_pop = -1; done_k = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (cyc_pop && first_pop < 0) first_pop = k;
      if (cyc_pop) last_pop = k;
      if (cyc_done) begin done_k = k; break; end
    end
    chk("t2_first_valid", 64'(first_pop), 64'd2);
    chk("t2_last_valid", 64'(last_pop), 64'd5);
    chk("t2_done_cycle", 64'(done_k), 64'd6);
    chk("t2_popped", 64'(popped), 64'd4);
    chk("t2_rd_q_empty", 64'(rd_q.size()), 64'd0);

    // 3: fill 8 random words, then read them with m_ready 1,0,0,1,...
    start_burst(1'b0, 8'd8);
    for (int i = 0; i < 8; i++) begin
      push_write(AW'(i), $urandom);
      step();
    end
    s_valid = 1'b0;
    step();
    chk("t3_fill_done", 64'(cyc_done), 64'd1);
    for (int i = 0; i < 8; i++) rd_q.push_back(shadow[i]);
    m_ready = 1'b1;
    start_burst(1'b1, 8'd8);
    last_pop = -1; done_k = -1;
    for (int k = 0; k < 60; k++) begin
      m_ready = ((k % 4) == 0) || ((k % 4) == 3);
      step();
      if (cyc_pop) last_pop = k;
      if (cyc_done) begin done_k = k; break; end
    end
    m_ready = 1'b0;
    chk("t3_no_timeout", 64'(done_k >= 0), 64'd1);
    chk("t3_done_after_pop", 64'(done_k), 64'(last_pop + 1));
    chk("t3_popped", 64'(popped), 64'd8);
    chk("t3_issued", 64'(issued), 64'd8);
    chk("t3_rd_q_empty", 64'(rd_q.size()), 64'd0);

    // 4: write with valid gaps 1,0,1,1,0,1
    gap_pat = 6'b101101;
    start_burst(1'b0, 8'd4);
    j = 0;
    for (int k = 0; k < 6; k++) begin
      if (gap_pat[k]) begin
        push_write(AW'(j), 32'hC0C0_0000 + DW'(j));
        j++;
      end else begin
        s_valid = 1'b0;
      end
      step();
      chk("t4_ce_follows_valid", 64'(cyc_ce), 64'(gap_pat[k]));
    end
    s_valid = 1'b0;
    step();
    chk("t4_done", 64'(cyc_done), 64'd1);
    chk("t4_writes", 64'(wr_count), 64'd4);

    // 5a: zero-length burst
    start_burst(1'b1, 8'd0);
    step();
    chk("t5a_done", 64'(cyc_done), 64'd1);
    chk("t5a_no_ce", 64'(cyc_ce), 64'd0);
    #1;
    chk("t5a_idle", 64'(idle), 64'd1);

    // 5b: start pulsed during a busy write burst is ignored
    start_burst(1'b0, 8'd3);
    for (int i = 0; i < 3; i++) begin
      push_write(AW'(i), 32'hD0D0_0000 + DW'(i));
      if (i == 1) begin start = 1'b1; mode = 1'b1; len = 8'd5; end
      step();
      start = 1'b0; mode = 1'b0; len = '0;
    end
    s_valid = 1'b0;
    step();
    chk("t5b_done", 64'(cyc_done), 64'd1);
    chk("t5b_writes", 64'(wr_count), 64'd3);
    step();
    chk("t5b_no_read", 64'(cyc_ce), 64'd0);

    // 5c: maximum length burst
    start_burst(1'b0, 8'd255);
    for (int i = 0; i < 255; i++) begin
      push_write(AW'(i), 32'h0101_0101 * DW'(i));
      step();
    end
    s_valid = 1'b0;
    step();
    chk("t5c_done", 64'(cyc_done), 64'd1);
    chk("t5c_writes", 64'(wr_count), 64'd255);
    chk("t5c_last_addr", 64'(last_wr_addr), 64'd254);

    // 6: reset mid-read with one word buffered
    m_ready = 1'b0;
    start_burst(1'b1, 8'd4);
    step();
    step();
    #1;
    chk("t6_fifo_has_word", 64'(m_valid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_rst_idle", 64'(idle), 64'd1);
    chk("t6_rst_m_valid", 64'(m_valid), 64'd0);
    chk("t6_rst_m_data", 64'(m_data), 64'd0);
    chk("t6_rst_ce", 64'(bram_ce), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    m_ready = 1'b1;
    done_cnt = 0; issued = 0;
    for (int k = 0; k < 5; k++) step();
    chk("t6_no_done", 64'(done_cnt), 64'd0);
    chk("t6_no_stale_issue", 64'(issued), 64'd0);
    start_burst(1'b0, 8'd2);
    for (int i = 0; i < 2; i++) begin
      push_write(AW'(i), 32'hE0E0_0000 + DW'(i));
      step();
    end
    s_valid = 1'b0;
    step();
    chk("t6_wr_restart_done", 64'(cyc_done), 64'd1);
    chk("t6_wr_q_empty", 64'(wr_q.size()), 64'd0);
    rd_q.push_back(shadow[0]);
    start_burst(1'b1, 8'd1);
    done_k = -1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (cyc_done) begin done_k = k; break; end
    end
    chk("t6_rd_restart_done", 64'(done_k), 64'd3);
    chk("t6_rd_q_empty", 64'(rd_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
